// File: rtl/cfg_runtime_regfile.sv
// rtl/cfg_runtime_regfile.sv - runtime configuration register file with shadow/active copies and drained apply handshake
//
// Purpose: holds NrRegs configuration words. Software writes land in a shadow copy;
// the hardware-visible active copy is loaded from the shadow only after the pipeline
// has been drained through the apply handshake (IDLE -> DRAIN -> COMMIT).
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i/be_i     register access request (held until gnt_o)
//   gnt_o                              access accepted this cycle (only in IDLE)
//   rvalid_o/rdata_o/err_o             response, one cycle after grant
//   apply_req_i                        level request to commit shadow to active
//   apply_busy_o/apply_done_o/apply_err_o  apply status, done/err are one-cycle pulses
//   flush_req_o/drained_i              pipeline drain handshake
//   lock_i/locked_o                    sticky write lock
//   dirty_o                            shadow differs from active
//   cfg_active_o                       active configuration, word i at [i*DataWidth +: DataWidth]

module cfg_runtime_regfile #(
    parameter int unsigned NrRegs       = 8,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned AddrWidth    = 4,
    parameter logic [NrRegs*DataWidth-1:0] ResetVal = '0,
    parameter logic [NrRegs*DataWidth-1:0] WrMask   = '1,
    parameter int unsigned DrainTimeout = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AddrWidth-1:0]        addr_i,
    input  logic [DataWidth-1:0]        wdata_i,
    input  logic [DataWidth/8-1:0]      be_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [DataWidth-1:0]        rdata_o,
    output logic                        err_o,
    input  logic                        apply_req_i,
    output logic                        apply_busy_o,
    output logic                        apply_done_o,
    output logic                        apply_err_o,
    output logic                        flush_req_o,
    input  logic                        drained_i,
    input  logic                        lock_i,
    output logic                        locked_o,
    output logic                        dirty_o,
    output logic [NrRegs*DataWidth-1:0] cfg_active_o
);

    localparam int unsigned NrBytes  = DataWidth / 8;
    localparam int unsigned IdxWidth = (NrRegs > 1) ? $clog2(NrRegs) : 1;
    localparam int unsigned CntWidth = $clog2(DrainTimeout + 1);
    localparam logic [AddrWidth:0]   NrRegsExt = (AddrWidth + 1)'(NrRegs);
    localparam logic [CntWidth-1:0]  CntLast   = CntWidth'(DrainTimeout - 1);

    typedef logic [NrRegs-1:0][DataWidth-1:0] cfgArrT;
    typedef enum logic [1:0] {Idle, Drain, Commit} applyStateT;

    localparam cfgArrT ResetArr  = cfgArrT'(ResetVal);
    localparam cfgArrT WrMaskArr = cfgArrT'(WrMask);

    applyStateT            stateQ, stateD;
    logic [CntWidth-1:0]   cntQ, cntD;
    cfgArrT                shadowQ, shadowD, activeQ, activeD;
    logic                  rvalidQ, errQ, lockedQ, dirtyQ;
    logic [DataWidth-1:0]  rdataQ;

    logic                  gnt, addrErr, accErr;
    logic [IdxWidth-1:0]   idx;
    logic [DataWidth-1:0]  byteMask, wrBits;

    assign idx = addr_i[IdxWidth-1:0];

    // Access path: decode, grant and next shadow value.
    always_comb begin
        addrErr  = {1'b0, addr_i} >= NrRegsExt;
        accErr   = addrErr || (we_i && lockedQ);
        // Reset gates the grant so nothing is accepted while the block is held in reset.
        gnt      = rst_ni && req_i && (stateQ == Idle);
        byteMask = '0;
        for (int k = 0; k < NrBytes; k++) begin
            byteMask[k*8 +: 8] = {8{be_i[k]}};
        end
        wrBits  = '0;
        shadowD = shadowQ;
        if (gnt && we_i && !accErr) begin
            wrBits       = byteMask & WrMaskArr[idx];
            shadowD[idx] = (shadowQ[idx] & ~wrBits) | (wdata_i & wrBits);
        end
        // No access is granted during COMMIT, so the whole shadow snapshot is consistent.
        activeD = (stateQ == Commit) ? shadowQ : activeQ;
    end

    // Apply FSM: next state and outputs.
    always_comb begin
        stateD       = stateQ;
        cntD         = cntQ;
        flush_req_o  = 1'b0;
        apply_done_o = 1'b0;
        apply_err_o  = 1'b0;
        case (stateQ)
            Idle: begin
                if (apply_req_i) begin
                    stateD = Drain;
                    cntD   = '0;
                end
            end
            Drain: begin
                flush_req_o = 1'b1;
                cntD        = cntQ + CntWidth'(1);
                if (drained_i) begin
                    stateD = Commit;
                end else if (cntQ == CntLast) begin
                    stateD      = Idle;
                    apply_err_o = 1'b1;
                end
            end
            Commit: begin
                apply_done_o = 1'b1;
                stateD       = Idle;
            end
            default: stateD = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ <= Idle;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadowQ <= ResetArr;
            activeQ <= ResetArr;
            rvalidQ <= 1'b0;
            errQ    <= 1'b0;
            rdataQ  <= '0;
            lockedQ <= 1'b0;
            dirtyQ  <= 1'b0;
        end else begin
            shadowQ <= shadowD;
            activeQ <= activeD;
            rvalidQ <= gnt;
            errQ    <= gnt && accErr;
            rdataQ  <= (gnt && !we_i && !accErr) ? shadowQ[idx] : '0;
            lockedQ <= lockedQ || lock_i;
            // Compared on next-state values so dirty tracks the registers without extra lag.
            dirtyQ  <= (shadowD != activeD);
        end
    end

    assign gnt_o        = gnt;
    assign rvalid_o     = rvalidQ;
    assign err_o        = errQ;
    assign rdata_o      = rdataQ;
    assign locked_o     = lockedQ;
    assign dirty_o      = dirtyQ;
    assign apply_busy_o = (stateQ != Idle);
    assign cfg_active_o = activeQ;

endmodule

// File: tb/tb_cfg_runtime_regfile.sv
// tb/tb_cfg_runtime_regfile.sv - self-checking bench for cfg_runtime_regfile
module tb_cfg_runtime_regfile;

    localparam int TO = 4;
    localparam logic [511:0] RV = {
        64'hC0DE_0000_0000_0007, 64'hC0DE_0000_0000_0006,
        64'hC0DE_0000_0000_0005, 64'hC0DE_0000_0000_0004,
        64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
        64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};
    // Top byte of word 3 is not writable.
    localparam logic [511:0] WM = ~({{504{1'b0}}, 8'hFF} << 248);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_i, we_i, apply_req_i, drained_i, lock_i;
    logic [3:0]   addr_i;
    logic [63:0]  wdata_i;
    logic [7:0]   be_i;
    logic         gnt, rvalid, err, busy, done, aerr, flush, locked, dirty;
    logic [63:0]  rdata;
    logic [511:0] cfg;

    int errors = 0;
    int checks = 0;
    logic modelReady = 1'b0;

    cfg_runtime_regfile #(
        .NrRegs(8), .DataWidth(64), .AddrWidth(4),
        .ResetVal(RV), .WrMask(WM), .DrainTimeout(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .apply_req_i(apply_req_i), .apply_busy_o(busy), .apply_done_o(done),
        .apply_err_o(aerr), .flush_req_o(flush), .drained_i(drained_i),
        .lock_i(lock_i), .locked_o(locked), .dirty_o(dirty), .cfg_active_o(cfg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 = idle, 1 = draining, 2 = committing.
    logic [63:0] mShadow [8];
    logic [63:0] mActive [8];
    int          mPhase, mDrainCycles;
    logic        mRvalid, mErr, mLocked, mDirty;
    logic [63:0] mRdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mShadow[i] = RV[i*64 +: 64];
                mActive[i] = RV[i*64 +: 64];
            end
            mPhase = 0; mDrainCycles = 0;
            mRvalid = 0; mErr = 0; mLocked = 0; mDirty = 0; mRdata = '0;
        end else begin
            logic        bad;
            logic [63:0] m;
            logic [511:0] wmv;
            mRvalid = 0; mErr = 0; mRdata = '0;
            if (req_i && mPhase == 0) begin
                bad = (addr_i >= 8) || (we_i && mLocked);
                mRvalid = 1;
                mErr = bad;
                if (!bad && !we_i) mRdata = mShadow[addr_i[2:0]];
                if (!bad && we_i) begin
                    wmv = WM;
                    m = '0;
                    for (int k = 0; k < 8; k++) if (be_i[k]) m[k*8 +: 8] = 8'hFF;
                    m = m & wmv[addr_i[2:0]*64 +: 64];
                    mShadow[addr_i[2:0]] = (mShadow[addr_i[2:0]] & ~m) | (wdata_i & m);
                end
            end
            case (mPhase)
                0: if (apply_req_i) begin mPhase = 1; mDrainCycles = 1; end
                1: if (drained_i) mPhase = 2;
                   else if (mDrainCycles == TO) mPhase = 0;
                   else mDrainCycles++;
                default: begin
                    for (int i = 0; i < 8; i++) mActive[i] = mShadow[i];
                    mPhase = 0;
                end
            endcase
            mLocked = mLocked | lock_i;
            mDirty = 0;
            for (int i = 0; i < 8; i++) if (mShadow[i] != mActive[i]) mDirty = 1;
        end
    end

    always @(negedge clk) begin
        if (modelReady) begin
            logic [511:0] eCfg;
            for (int i = 0; i < 8; i++) eCfg[i*64 +: 64] = mActive[i];
            check("gnt", gnt, rst_n && req_i && mPhase == 0);
            check("rvalid", rvalid, mRvalid);
            check("err", err, mErr);
            check("rdata", rdata, mRdata);
            check("busy", busy, mPhase != 0);
            check("flush", flush, mPhase == 1);
            check("done", done, mPhase == 2);
            check("apply_err", aerr, mPhase == 1 && !drained_i && mDrainCycles == TO);
            check("locked", locked, mLocked);
            check("dirty", dirty, mDirty);
            check("cfg_active", cfg, eCfg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the grant edge, while the response is on the outputs.
    task automatic access(input logic we, input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
        int n = 0;
        req_i = 1; we_i = we; addr_i = a; wdata_i = d; be_i = be;
        @(negedge clk);
        while (!gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", n < 20, 1'b1);
        tick();
        req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    endtask

    initial begin
        rst_n = 0; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
        apply_req_i = 0; drained_i = 0; lock_i = 0;
        repeat (2) @(posedge clk);
        #1 modelReady = 1;
        rst_n = 1;

        // Reset state and first read.
        @(negedge clk);
        check("lit_reset_cfg", cfg, RV);
        check("lit_reset_dirty", dirty, 1'b0);
        access(0, 4'd2, '0, '0);
        check("lit_rd2_valid", rvalid, 1'b1);
        check("lit_rd2_data", rdata, 64'hC0DE_0000_0000_0002);
        check("lit_rd2_err", err, 1'b0);

        // Partial byte write, then masked-bit write.
        access(1, 4'd1, 64'hDEAD_BEEF_0000_1111, 8'h0F);
        access(0, 4'd1, '0, '0);
        check("lit_rd1_data", rdata, 64'hC0DE_0000_0000_1111);
        check("lit_dirty_after_wr", dirty, 1'b1);
        check("lit_cfg_unchanged", cfg, RV);
        access(1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        access(0, 4'd3, '0, '0);
        check("lit_rd3_masked", rdata, 64'hC0FF_FFFF_FFFF_FFFF);

        // Apply with drain acknowledged in the third flush cycle; read held across it.
        apply_req_i = 1;
        tick();
        apply_req_i = 0; req_i = 1; we_i = 0; addr_i = 4'd1;
        @(negedge clk);
        check("lit_drain_no_gnt", gnt, 1'b0);
        check("lit_drain_flush", flush, 1'b1);
        tick();
        tick();
        drained_i = 1;
        tick();
        drained_i = 0;
        @(negedge clk);
        check("lit_commit_done", done, 1'b1);
        check("lit_commit_no_gnt", gnt, 1'b0);
        tick();
        @(negedge clk);
        check("lit_idle_gnt", gnt, 1'b1);
        check("lit_cfg_word1", cfg[127:64], 64'hC0DE_0000_0000_1111);
        check("lit_dirty_cleared", dirty, 1'b0);
        tick();
        req_i = 0;
        check("lit_held_rd_data", rdata, 64'hC0DE_0000_0000_1111);

        // Drain timeout.
        access(1, 4'd0, 64'h0000_0000_0000_1234, 8'hFF);
        apply_req_i = 1;
        tick();
        apply_req_i = 0;
        tick();
        tick();
        tick();
        @(negedge clk);
        check("lit_timeout_pulse", aerr, 1'b1);
        tick();
        @(negedge clk);
        check("lit_timeout_idle", busy, 1'b0);
        check("lit_timeout_dirty", dirty, 1'b1);
        check("lit_timeout_cfg0", cfg[63:0], 64'hC0DE_0000_0000_0000);

        // Held apply request re-triggers after the minimum round trip.
        apply_req_i = 1; drained_i = 1;
        tick();
        tick();
        tick();
        tick();
        @(negedge clk);
        check("lit_retrigger_busy", busy, 1'b1);
        apply_req_i = 0;
        tick();
        tick();
        drained_i = 0;
        check("lit_cfg_word0", cfg[63:0], 64'h0000_0000_0000_1234);

        // Lock and out-of-range access.
        lock_i = 1;
        tick();
        lock_i = 0;
        @(negedge clk);
        check("lit_locked", locked, 1'b1);
        access(1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        check("lit_locked_wr_err", err, 1'b1);
        access(0, 4'd0, '0, '0);
        check("lit_locked_rd0", rdata, 64'h0000_0000_0000_1234);
        check("lit_locked_rd0_err", err, 1'b0);
        access(0, 4'd9, '0, '0);
        check("lit_oor_err", err, 1'b1);
        check("lit_oor_data", rdata, 64'h0);

        // Asynchronous reset in the middle of a drain.
        apply_req_i = 1;
        tick();
        apply_req_i = 0;
        #2 rst_n = 0;
        #1;
        check("lit_rst_busy", busy, 1'b0);
        check("lit_rst_flush", flush, 1'b0);
        check("lit_rst_locked", locked, 1'b0);
        check("lit_rst_cfg", cfg, RV);
        check("lit_rst_dirty", dirty, 1'b0);
        tick();
        rst_n = 1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
